// File: rtl/io_pkg.sv
// io_pkg: register offsets, UART state encoding and UART_STAT bit positions for io_port_bank
package io_pkg;
  localparam logic [7:0] IO_GPIO_OUT   = 8'h00;
  localparam logic [7:0] IO_GPIO_IN    = 8'h04;
  localparam logic [7:0] IO_UART_DATA  = 8'h08;
  localparam logic [7:0] IO_UART_STAT  = 8'h0C;
  localparam logic [7:0] IO_CYCLE      = 8'h10;
  localparam logic [7:0] IO_TIMER_CMP  = 8'h14;
  localparam logic [7:0] IO_TIMER_STAT = 8'h18;
  typedef enum logic [1:0] {UART_IDLE, UART_START, UART_DATA, UART_STOP} uart_state_e;
  localparam int STAT_BUSY  = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_EMPTY = 2;
  localparam int STAT_OVF   = 3;
endpackage

// File: rtl/io_uart_tx.sv
// io_uart_tx: byte FIFO feeding an 8N1 serial transmitter, CLK_DIV clocks per bit
module io_uart_tx
  import io_pkg::*;
#(
  parameter int CLK_DIV        = 104,
  parameter int FIFO_DEPTH_LOG = 2
) (
  input  logic       clk,
  input  logic       resetb,
  input  logic       push,
  input  logic [7:0] push_data,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       txd
);
  localparam int L     = FIFO_DEPTH_LOG;
  localparam int PW    = L + 1;
  localparam int DEPTH = 1 << L;
  localparam int CW    = $clog2(CLK_DIV);

  logic [7:0]    fifo_mem [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          txd_q, txd_d;
  uart_state_e   state_q, state_d;
  logic          do_push, do_pop, tick;

  assign empty = wr_q == rd_q;
  assign full  = (wr_q[L] != rd_q[L]) && (wr_q[L-1:0] == rd_q[L-1:0]);
  assign busy  = state_q != UART_IDLE;
  assign txd   = txd_q;

  // FIFO pointers, baud counter and frame sequencing; txd is registered so the line is glitch-free
  always_comb begin
    do_push = push && !full;
    do_pop  = (state_q == UART_IDLE) && !empty;
    tick    = cnt_q == CW'(CLK_DIV - 1);
    wr_d    = do_push ? wr_q + PW'(1) : wr_q;
    rd_d    = do_pop ? rd_q + PW'(1) : rd_q;
    cnt_d   = (state_q == UART_IDLE || tick) ? '0 : cnt_q + CW'(1);
    state_d = state_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    case (state_q)
      UART_IDLE: if (do_pop) begin
        state_d = UART_START;
        sh_d    = fifo_mem[rd_q[L-1:0]];
      end
      UART_START: if (tick) begin
        state_d = UART_DATA;
        bit_d   = '0;
      end
      UART_DATA: if (tick) begin
        sh_d    = sh_q >> 1;
        bit_d   = bit_q + 3'd1;
        state_d = (bit_q == 3'd7) ? UART_STOP : UART_DATA;
      end
      default: if (tick) state_d = UART_IDLE;
    endcase
    txd_d = (state_q == UART_START) ? 1'b0 : (state_q == UART_DATA) ? sh_q[0] : 1'b1;
  end

  // FIFO storage; a push is only accepted while the FIFO is not full
  always_ff @(posedge clk) begin
    if (do_push) fifo_mem[wr_q[L-1:0]] <= push_data;
  end

  // state registers; reset abandons any frame in flight and idles the line high
  always_ff @(posedge clk) begin
    if (!resetb) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      txd_q   <= 1'b1;
      state_q <= UART_IDLE;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      txd_q   <= txd_d;
      state_q <= state_d;
    end
  end
endmodule

// File: rtl/io_port_bank.sv
// io_port_bank: MMIO responder with GPIO, UART TX, cycle counter; compare timer built when IO_PORT_TIMER_EN is defined
module io_port_bank
  import io_pkg::*;
#(
  parameter int GPIO_W         = 8,
  parameter int CLK_DIV        = 104,
  parameter int FIFO_DEPTH_LOG = 2
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic [7:0]        io_addr,
  input  logic              io_en,
  input  logic              io_we,
  input  logic [31:0]       io_data_write,
  output logic [31:0]       io_data_read,
  output logic [GPIO_W-1:0] gpio_out,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic              uart_txd,
  output logic              timer_irq
);
  logic [7:0]        addr_w;
  logic              wr;
  logic              push, full, empty, busy;
  logic [GPIO_W-1:0] gpio_q, gpio_d, sync1_q, sync1_d, sync2_q, sync2_d;
  logic [31:0]       cyc_q, cyc_d;
  logic              ovf_q, ovf_d;
  logic [3:0]        stat;
  logic [31:0]       rdata;

  assign addr_w   = io_addr & 8'hFC;
  assign wr       = io_en && io_we;
  assign push     = wr && addr_w == IO_UART_DATA;
  assign gpio_out = gpio_q;

  io_uart_tx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH_LOG(FIFO_DEPTH_LOG)) u_tx (
    .clk      (clk),
    .resetb   (resetb),
    .push     (push),
    .push_data(io_data_write[7:0]),
    .full     (full),
    .empty    (empty),
    .busy     (busy),
    .txd      (uart_txd)
  );

  // register writes, input synchronizer, cycle counter and sticky overflow (set beats clear)
  always_comb begin
    gpio_d  = (wr && addr_w == IO_GPIO_OUT) ? io_data_write[GPIO_W-1:0] : gpio_q;
    sync1_d = gpio_in;
    sync2_d = sync1_q;
    cyc_d   = (wr && addr_w == IO_CYCLE) ? io_data_write : cyc_q + 32'd1;
    ovf_d   = (push && full) ? 1'b1 :
              (wr && addr_w == IO_UART_STAT && io_data_write[STAT_OVF]) ? 1'b0 : ovf_q;
  end

  // core registers
  always_ff @(posedge clk) begin
    if (!resetb) begin
      gpio_q  <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      cyc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      gpio_q  <= gpio_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cyc_q   <= cyc_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef IO_PORT_TIMER_EN
  logic [31:0] cmp_q, cmp_d;
  logic        match_q, match_d;

  assign timer_irq = match_q;

  // compare register and sticky match flag; a match in the same cycle beats a clear
  always_comb begin
    cmp_d   = (wr && addr_w == IO_TIMER_CMP) ? io_data_write : cmp_q;
    match_d = (cyc_q == cmp_q) ? 1'b1 :
              (wr && addr_w == IO_TIMER_STAT && io_data_write[0]) ? 1'b0 : match_q;
  end

  // timer registers
  always_ff @(posedge clk) begin
    if (!resetb) begin
      cmp_q   <= 32'hFFFF_FFFF;
      match_q <= 1'b0;
    end else begin
      cmp_q   <= cmp_d;
      match_q <= match_d;
    end
  end
`else
  assign timer_irq = 1'b0;
`endif

  // combinational read mux; only reads (io_en && !io_we) drive non-zero data
  always_comb begin
    stat             = '0;
    stat[STAT_BUSY]  = busy;
    stat[STAT_FULL]  = full;
    stat[STAT_EMPTY] = empty;
    stat[STAT_OVF]   = ovf_q;
    rdata            = '0;
    case (addr_w)
      IO_GPIO_OUT:   rdata = 32'(gpio_q);
      IO_GPIO_IN:    rdata = 32'(sync2_q);
      IO_UART_STAT:  rdata = 32'(stat);
      IO_CYCLE:      rdata = cyc_q;
`ifdef IO_PORT_TIMER_EN
      IO_TIMER_CMP:  rdata = cmp_q;
      IO_TIMER_STAT: rdata = 32'(match_q);
`endif
      default:       rdata = '0;
    endcase
    io_data_read = (io_en && !io_we) ? rdata : '0;
  end
endmodule

// File: doc/io_port_bank.md
Name: io_port_bank

Overview:
- Memory-mapped I/O responder on the MMU I/O port, covering addresses 0x80000000-0x800000FF, which the MMU presents as 8-bit io_addr.
- Provides GPIO output and input, a UART transmitter with a small FIFO, a free-running cycle counter and an optional compare timer.
- Reads are combinational, so data is valid in the same cycle the MMU presents its registered io_addr/io_en. Writes commit at the clock edge that ends that cycle.

Parameters:
- GPIO_W, 8, width of gpio_out and gpio_in.
- CLK_DIV, 104, clk cycles per UART bit (minimum 2).
- FIFO_DEPTH_LOG, 2, log2 of UART TX FIFO depth (4 entries).

Ports:
- clk  in  1  clock
- resetb  in  1  synchronous active-low reset
- io_addr  in  8  byte address; bits [1:0] ignored
- io_en  in  1  access strobe, one cycle per access
- io_we  in  1  write when io_en=1
- io_data_write  in  32  write data; upper lanes may be X on byte/half stores
- io_data_read  out  32  read data, combinational
- gpio_out  out  GPIO_W  output register
- gpio_in  in  GPIO_W  asynchronous inputs
- uart_txd  out  1  serial output, idle high
- timer_irq  out  1  compare match flag (constant 0 without feature)

Behaviour:
- Reset: resetb sampled at posedge clk.
  - Outputs: gpio_out=0, uart_txd=1, timer_irq=0.
  - Internal state: FIFO empty, overflow=0, cycle=0, TIMER_CMP=0xFFFFFFFF, UART state IDLE.
  - Reset mid-frame abandons the frame; txd is 1 after that edge.
- Register map (word offsets; writes of 8-bit fields use io_data_write[7:0] only):
  - 0x00 GPIO_OUT: RW, GPIO_W bits.
  - 0x04 GPIO_IN: RO; 2-flop synchronized gpio_in, 2-cycle latency.
  - 0x08 UART_DATA: W enqueues [7:0]; R returns 0.
  - 0x0C UART_STAT: R returns {28'b0, overflow, empty, full, busy}. W with bit3=1 clears overflow.
  - 0x10 CYCLE: R returns the 32-bit counter. W loads io_data_write.
  - 0x14 TIMER_CMP and 0x18 TIMER_STAT: optional feature only.
  - All other offsets: read 0, writes ignored.
- io_data_read is 0 when io_en=0 or io_we=1. Reads have no side effects.
- Cycle counter:
  - Increments every cycle; wraps 0xFFFFFFFF to 0.
  - A write wins over the increment; the counter holds the written value for one cycle, then increments.
- UART FIFO:
  - Write to UART_DATA when full (state before the edge) drops the byte and sets overflow, even if a pop occurs the same cycle.
  - Overflow is sticky; set wins over a simultaneous clear.
- UART shifter FSM: IDLE -> START -> DATA -> STOP -> IDLE, each bit lasting CLK_DIV cycles.
  - IDLE: txd=1. If the FIFO is non-empty, pop and go to START.
  - START: txd=0.
  - DATA: 8 bits, LSB first, 3-bit bit index.
  - STOP: txd=1.
  - Back-to-back frame starts are 10*CLK_DIV+1 cycles apart, i.e. one idle cycle between frames.
  - busy = (state != IDLE).
  - An enqueue into an empty FIFO while IDLE makes txd fall 2 edges after the write edge.

Optional Feature:
- Macro: IO_PORT_TIMER_EN.
- With the macro:
  - 0x14 TIMER_CMP is RW 32-bit.
  - 0x18 TIMER_STAT bit0 = match flag. The flag is set the cycle after cycle==TIMER_CMP and is sticky. A write with bit0=1 clears it; set wins over clear.
  - timer_irq = match flag.
- Without the macro: 0x14/0x18 read 0, writes are ignored, timer_irq is tied 0, and no compare logic is built.

Decomposition:
- Package io_pkg holds:
  - register offset constants (IO_GPIO_OUT, IO_GPIO_IN, IO_UART_DATA, IO_UART_STAT, IO_CYCLE, IO_TIMER_CMP, IO_TIMER_STAT);
  - UART FSM state encoding (UART_IDLE, UART_START, UART_DATA, UART_STOP);
  - UART_STAT bit indices.
- Sub-module io_uart_tx contains the FIFO, baud counter and shifter.
  - Interface: push, push_data, full, empty, busy, txd.
  - io_port_bank keeps the address decode, GPIO, counter, timer and overflow logic.

Test Plan:
- Reset, then read 0x00, 0x0C and 0x10 on the following cycles -> 0, 0x4 (empty only), and a small count; uart_txd=1 throughout.
- Write 0x5A to 0x00, read 0x00 next cycle -> gpio_out=0x5A, read data 0x5A. Drive gpio_in=0xA5 -> read of 0x04 returns 0xA5 from the 3rd cycle after the change.
- CLK_DIV=4, write 0x55 to 0x08 -> txd low 4 cycles, then bits 1,0,1,0,1,0,1,0 (4 cycles each), then high; busy=1 during the frame.
- Write 6 bytes on consecutive cycles while IDLE -> the first pops immediately, 4 are queued, the last is dropped, and UART_STAT reads 0xB (overflow, full, busy). Writing 0x8 to 0x0C clears overflow.
- Write 0xFFFFFFFE to 0x10 -> reads return 0xFFFFFFFE, then 0xFFFFFFFF, then 0 on successive cycles.
- With IO_PORT_TIMER_EN: TIMER_CMP=100, CYCLE=90 -> timer_irq rises 11 cycles after the CYCLE write and stays high; writing 1 to 0x18 clears it.
